bsg_imul_iterative_shift_add: RTL and testbench

- Iterative N-bit integer multiplier producing the full 2N-bit product; signed or unsigned mode is selected per request.
- Companion to the team's iterative divider, and uses the same request/result handshake: v_i/ready_and_o on input, v_o/yumi_i on output.
- Sits beside the divider in the integer long-latency unit. It reuses the divider's sign-magnitude approach: take absolute values, run an unsigned shift-add loop, then conditionally negate the result.

---
 rtl/bsg_imul_iterative_shift_add_if.sv | 29 ++
 rtl/bsg_imul_iterative_shift_add.sv | 132 +++++++++++++
 tb/tb_bsg_imul_iterative_shift_add.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bsg_imul_iterative_shift_add_if.sv
`default_nettype none
// ============================================================================
// Module   : bsg_imul_iterative_shift_add_if
// Purpose  : Request/result handshake bundle for the iterative multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface bsg_imul_iterative_shift_add_if #(
    parameter int width_p = 32
);
    logic                   v_i;
    logic                   ready_and_o;
    logic [width_p-1:0]     opA_i;
    logic [width_p-1:0]     opB_i;
    logic                   signed_i;
    logic                   v_o;
    logic [2*width_p-1:0]   result_o;
    logic                   yumi_i;

    modport slave (
        input  v_i, opA_i, opB_i, signed_i, yumi_i,
        output ready_and_o, v_o, result_o
    );

    modport master (
        output v_i, opA_i, opB_i, signed_i, yumi_i,
        input  ready_and_o, v_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_imul_iterative_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : bsg_imul_iterative_shift_add
// Purpose  : Iterative sign-magnitude shift/add multiplier, full 2N-bit product.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_imul_iterative_shift_add #(
    parameter int width_p         = 32,
    parameter int bits_per_iter_p = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    bsg_imul_iterative_shift_add_if.slave  bus
);

    localparam int c_BPI    = (bits_per_iter_p > 0) ? bits_per_iter_p : 1;
    localparam int c_ITERS  = width_p / c_BPI;
    localparam int c_CNT_W  = (c_ITERS > 1) ? $clog2(c_ITERS) : 1;
    localparam int c_EXT_W  = width_p + c_BPI;
    localparam int c_PROD_W = 2 * width_p;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITERS - 1);

    if (!((bits_per_iter_p == 1) || (bits_per_iter_p == 2) || (bits_per_iter_p == 4))
        || ((width_p % c_BPI) != 0)) begin : g_bad_params
        $error("bits_per_iter_p must be 1, 2 or 4 and divide width_p");
    end

    typedef enum logic [1:0] {
        eIDLE = 2'd0,
        eCALC = 2'd1,
        eNEG  = 2'd2,
        eDONE = 2'd3
    } state_e;

    state_e                 state_q;
    logic [c_CNT_W-1:0]     cnt_q;
    logic [width_p-1:0]     magA_q;
    logic [width_p-1:0]     acc_q;
    logic [width_p-1:0]     mult_q;
    logic                   neg_q;
    logic                   ready_q;
    logic                   v_q;
    logic [c_PROD_W-1:0]    result_q;

    logic [width_p-1:0]     w_mag_a;
    logic [width_p-1:0]     w_mag_b;
    logic                   w_neg;
    logic [c_EXT_W-1:0]     w_pp;
    logic [c_EXT_W-1:0]     w_acc_ext;
    logic [c_PROD_W-1:0]    w_shifted;
    logic [c_PROD_W-1:0]    w_product;

    // The most-negative operand maps onto itself, which is its correct unsigned magnitude.
    assign w_mag_a = (bus.signed_i && bus.opA_i[width_p-1]) ? (~bus.opA_i + width_p'(1)) : bus.opA_i;
    assign w_mag_b = (bus.signed_i && bus.opB_i[width_p-1]) ? (~bus.opB_i + width_p'(1)) : bus.opB_i;
    assign w_neg   = bus.signed_i & (bus.opA_i[width_p-1] ^ bus.opB_i[width_p-1]);

    always_comb begin
        w_pp = '0;
        for (int j = 0; j < c_BPI; j++) begin
            if (mult_q[j]) begin
                w_pp = w_pp + ({{c_BPI{1'b0}}, magA_q} << j);
            end
        end
    end

    assign w_acc_ext = {{c_BPI{1'b0}}, acc_q} + w_pp;
    // Retired multiplier bits drop off the bottom while new low product bits enter from acc.
    assign w_shifted = c_PROD_W'({w_acc_ext, mult_q} >> c_BPI);
    assign w_product = {acc_q, mult_q};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= eIDLE;
            cnt_q    <= '0;
            magA_q   <= '0;
            acc_q    <= '0;
            mult_q   <= '0;
            neg_q    <= 1'b0;
            ready_q  <= 1'b1;
            v_q      <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                eIDLE: begin
                    if (bus.v_i) begin
                        magA_q  <= w_mag_a;
                        mult_q  <= w_mag_b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        neg_q   <= w_neg;
                        ready_q <= 1'b0;
                        state_q <= eCALC;
                    end
                end
                eCALC: begin
                    acc_q  <= w_shifted[c_PROD_W-1:width_p];
                    mult_q <= w_shifted[width_p-1:0];
                    cnt_q  <= cnt_q + c_CNT_W'(1);
                    if (cnt_q == c_CNT_LAST) begin
                        state_q <= eNEG;
                    end
                end
                eNEG: begin
                    result_q <= neg_q ? (~w_product + c_PROD_W'(1)) : w_product;
                    v_q      <= 1'b1;
                    state_q  <= eDONE;
                end
                eDONE: begin
                    if (bus.yumi_i) begin
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= eIDLE;
                    end
                end
                default: begin
                    state_q <= eIDLE;
                end
            endcase
        end
    end

    assign bus.ready_and_o = ready_q;
    assign bus.v_o         = v_q;
    assign bus.result_o    = result_q;

    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) bus.yumi_i |-> v_q
    ) else $error("yumi_i asserted while v_o is low");

endmodule
`default_nettype wire

// File: tb/tb_bsg_imul_iterative_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_imul_iterative_shift_add
// Purpose  : Directed-vector bench for the iterative multiplier at 1, 2, 4 bits/iter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_imul_iterative_shift_add;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]             v_d;
    logic [2:0][W-1:0]      a_d;
    logic [2:0][W-1:0]      b_d;
    logic [2:0]             s_d;
    logic [2:0]             yumi_d;
    logic [2:0]             ready_v;
    logic [2:0]             vo_v;
    logic [2:0][2*W-1:0]    res_v;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BPI = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        bsg_imul_iterative_shift_add_if #(.width_p(W)) bus ();
        assign bus.v_i      = v_d[g];
        assign bus.opA_i    = a_d[g];
        assign bus.opB_i    = b_d[g];
        assign bus.signed_i = s_d[g];
        assign bus.yumi_i   = yumi_d[g];
        assign ready_v[g]   = bus.ready_and_o;
        assign vo_v[g]      = bus.v_o;
        assign res_v[g]     = bus.result_o;
        bsg_imul_iterative_shift_add #(
            .width_p         (W),
            .bits_per_iter_p (BPI)
        ) dut (
            .clk_i   (clk),
            .reset_i (rst),
            .bus     (bus.slave)
        );
    end

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t tv[10];
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{W{a[W-1]}}, a};
            sb = {{W{b[W-1]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Latency counts the accept cycle as cycle 1; inputs are scrambled right after accept.
    task automatic do_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, output logic [2*W-1:0] res, output int lat);
        int guard;
        guard = 0;
        while (!ready_v[idx] && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        v_d[idx] = 1'b1; a_d[idx] = a; b_d[idx] = b; s_d[idx] = s;
        @(posedge clk); #1;
        v_d[idx] = 1'b0; a_d[idx] = $urandom; b_d[idx] = $urandom; s_d[idx] = ~s;
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (vo_v[idx]) break;
        end
        if (vo_v[idx]) begin
            res = res_v[idx];
            yumi_d[idx] = 1'b1;
            @(posedge clk); #1;
            yumi_d[idx] = 1'b0;
        end else begin
            res = 'x;
            lat = -1;
        end
    endtask

    initial begin
        logic [2*W-1:0] r;
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;
        int             lat;
        int             guard;

        v_d = '0; a_d = '0; b_d = '0; s_d = '0; yumi_d = '0;

        tv[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        tv[1] = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        tv[2] = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 64'h0000_0006_FFFF_FFEB};
        tv[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        tv[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000};
        tv[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0000};
        tv[6] = '{32'h0000_0005, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_001E};
        tv[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        tv[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
        tv[9] = '{32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ready", 64'(ready_v[0]), 64'd1);
        check("reset_v_o",   64'(vo_v[0]),    64'd0);
        check("reset_result", res_v[0],       64'd0);

        for (int i = 0; i < 10; i++) begin
            do_op(0, tv[i].a, tv[i].b, tv[i].s, r, lat);
            check($sformatf("vec%0d_result", i), r, tv[i].exp);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
        end

        // Backpressure: result must hold while new requests are offered and ignored.
        v_d[0] = 1'b1; a_d[0] = 32'd3; b_d[0] = 32'd4; s_d[0] = 1'b0;
        @(posedge clk); #1;
        a_d[0] = 32'd7; b_d[0] = 32'd9;
        guard = 0;
        while (!vo_v[0] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold%0d_v_o", i),    64'(vo_v[0]),    64'd1);
            check($sformatf("hold%0d_result", i), res_v[0],        64'h0000_0000_0000_000C);
            check($sformatf("hold%0d_ready", i),  64'(ready_v[0]), 64'd0);
            @(posedge clk); #1;
        end
        v_d[0] = 1'b0;
        if (vo_v[0]) begin
            yumi_d[0] = 1'b1;
            @(posedge clk); #1;
            yumi_d[0] = 1'b0;
        end
        check("post_yumi_ready",  64'(ready_v[0]), 64'd1);
        check("post_yumi_v_o",    64'(vo_v[0]),    64'd0);
        check("idle_result_kept", res_v[0],        64'h0000_0000_0000_000C);

        // Reset during the 10th eCALC cycle.
        v_d[0] = 1'b1; a_d[0] = 32'hFFFF_FFFF; b_d[0] = 32'hFFFF_FFFF; s_d[0] = 1'b0;
        @(posedge clk); #1;
        v_d[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_ready",  64'(ready_v[0]), 64'd1);
        check("midreset_v_o",    64'(vo_v[0]),    64'd0);
        check("midreset_result", res_v[0],        64'd0);
        do_op(0, 32'd5, 32'd6, 1'b0, r, lat);
        check("after_reset_result",  r, 64'h0000_0000_0000_001E);
        check("after_reset_latency", 64'(lat), 64'd34);

        for (int k = 1; k < 3; k++) begin
            for (int n = 0; n < 150; n++) begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom_range(0, 1));
                if (n % 13 == 0) ra = 32'h8000_0000;
                if (n % 17 == 0) rb = 32'hFFFF_FFFF;
                if (n % 19 == 0) rb = 32'h0;
                do_op(k, ra, rb, rs, r, lat);
                check($sformatf("sweep%0d_%0d_result", k, n), r, model(ra, rb, rs));
                check($sformatf("sweep%0d_%0d_latency", k, n), 64'(lat), (k == 1) ? 64'd18 : 64'd10);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
